// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conv_arbiter
// Purpose  : Round-robin sharing of one free-running serial binary-to-BCD
//            engine (int2str) among pReq requesters. The winner's word is
//            steered onto the engine input. Launch and capture are aligned
//            to the engine frame strobe. The BCD string is returned with a
//            one-hot acknowledge pulse.
// Options  : BCD_ARB_LEADZERO_EN - blank leading zero digits (4'hF) at
//            capture. Digit 0 is never blanked.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
  parameter int pBitWidth = 16,
  parameter int pBins     = 4,
  parameter int pReq      = 4
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic [pReq-1:0]             iReq,
  input  logic [pReq*pBitWidth-1:0]   iBinary,
  output logic [pReq-1:0]             oAck,
  output logic [pReq-1:0]             oGrant,
  output logic                        oValid,
  output logic [$clog2(pReq)-1:0]     oValidId,
  output logic [4*pBins-1:0]          oString,
  output logic                        oBusy,
  output logic [pBitWidth-1:0]        oConvBinary,
  input  logic                        iConvDone,
  input  logic [4*pBins-1:0]          iConvString
);

  localparam int cIdW = $clog2(pReq);
  localparam int cStrW = 4 * pBins;
  localparam logic [pReq-1:0] cOneHot0 = {{(pReq-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    CONVERT = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t               state_q;
  logic [pReq-1:0]      grant_q;
  logic [cIdW-1:0]      gidx_q;
  logic [cIdW-1:0]      ptr_q;
  logic [pReq-1:0]      ack_q;
  logic                 valid_q;
  logic [cIdW-1:0]      validid_q;
  logic [cStrW-1:0]     string_q;

  logic                 win_found;
  logic [cIdW-1:0]      win_idx;
  logic [pBitWidth-1:0] conv_bin;

  // Result formatting applied at capture: optional leading-zero blanking
  // walks from the most significant digit down and stops at the first
  // non-zero digit; digit 0 is always kept so a zero value shows as "0".
  function automatic logic [cStrW-1:0] fmt_string(input logic [cStrW-1:0] s);
    logic [cStrW-1:0] r;
`ifdef BCD_ARB_LEADZERO_EN
    logic lead;
    r    = s;
    lead = 1'b1;
    for (int d = pBins - 1; d >= 1; d--) begin
      if (lead && (s[4*d +: 4] == 4'h0)) begin
        r[4*d +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
`else
    r = s;
`endif
    return r;
  endfunction

  // Round-robin search: first asserted request at or after the pointer,
  // scanning upward and wrapping past the top index.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < pReq; i++) begin
      j = int'(ptr_q) + i;
      if (j >= pReq) begin
        j = j - pReq;
      end
      if (!win_found && iReq[j]) begin
        win_found = 1'b1;
        win_idx   = cIdW'(j);
      end
    end
  end

  // Engine input mux driven by the registered one-hot grant; yields zero
  // whenever nobody holds the grant.
  always_comb begin
    conv_bin = '0;
    for (int k = 0; k < pReq; k++) begin
      if (grant_q[k]) begin
        conv_bin = conv_bin | iBinary[k*pBitWidth +: pBitWidth];
      end
    end
  end

  // Control FSM with registered outputs. Strobes seen while IDLE are
  // ignored, so the strobe on the edge that enters LAUNCH never launches.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      ack_q     <= '0;
      valid_q   <= 1'b0;
      validid_q <= '0;
      string_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q   <= '0;
          valid_q <= 1'b0;
          if (win_found) begin
            grant_q <= cOneHot0 << win_idx;
            gidx_q  <= win_idx;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Engine latches oConvBinary on this strobe edge.
          if (iConvDone) begin
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          // The next strobe carries the result of the launched word.
          if (iConvDone) begin
            string_q  <= fmt_string(iConvString);
            valid_q   <= 1'b1;
            ack_q     <= grant_q;
            validid_q <= gidx_q;
            state_q   <= RESULT;
          end
        end
        RESULT: begin
          valid_q   <= 1'b0;
          ack_q     <= '0;
          validid_q <= '0;
          grant_q   <= '0;
          // The winner just served drops to lowest priority.
          if (gidx_q == cIdW'(pReq - 1)) begin
            ptr_q <= '0;
          end else begin
            ptr_q <= gidx_q + 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oAck        = ack_q;
  assign oGrant      = grant_q;
  assign oValid      = valid_q;
  assign oValidId    = validid_q;
  assign oString     = string_q;
  assign oBusy       = (state_q != IDLE);
  assign oConvBinary = conv_bin;

endmodule
`default_nettype wire
